i2s_receiver: RTL and testbench
===============================

# i2s_receiver

I2S target-mode receiver: accepts an externally driven bit clock, word select and serial data line, synchronizes them into the system clock domain and deserializes stereo PCM frames into parallel left/right samples. Sits between an I2S source (ADC, MEMS microphone, codec output) and the audio datapath. It is the receive-side counterpart of the team's I2S DAC driver and uses the same framing: ws low = left, MSB one bck after the ws edge.

## Interface
- DATA_W, 24, captured sample width per channel; legal 8..32
- clk  in  1  system clock; frequency at least 4x bck
- rst_n  in  1  asynchronous active-low reset
- bck  in  1  I2S bit clock, asynchronous to clk
- ws  in  1  I2S word select, asynchronous to clk, changes on bck falling edge
- din  in  1  I2S serial data, asynchronous to clk, changes on bck falling edge
- left_data  out  DATA_W  left sample of the last accepted frame
- right_data  out  DATA_W  right sample of the last accepted frame
- valid  out  1  frame held in output register
- ready  in  1  consumer accepts the frame when valid && ready at a clk edge
- overrun  out  1  sticky: a complete frame was dropped because the output register was occupied
- frame_err  out  1  sticky: a slot ended before DATA_W bits were received (macro-dependent)

## Operation
- bck, ws and din each pass through 2 flops; a third bck flop gives rise detection. All capture logic advances only on a detected bck rise (the event "tick").
- At each tick, sample ws_now and din, and keep ws_d (ws at the previous tick) and ws_dd. The din bit belongs to channel ws_d. A slot starts when ws_d != ws_dd; the bit counter resets to 0 there.
- Bits are shifted MSB first into the active channel register at index DATA_W-1-count. The counter saturates at DATA_W; surplus bits in long slots are ignored. Short slots leave the remaining LSBs zero.
- States:
  - SYNC (reset state): discard all bits. Go to LEFT on the first tick with ws_d=1 and ws_now=0. That tick's bit is the right LSB and is discarded.
  - LEFT: capture into the left shift register. Go to RIGHT on the tick where ws_d=0 and ws_now=1, after capturing that tick's bit.
  - RIGHT: capture into the right shift register. On the tick where ws_d=1 and ws_now=0, capture the bit, then complete the frame and go to LEFT.
- Frame complete:
  - If valid=0, or valid && ready in the same cycle, load left_data/right_data and assert valid.
  - Otherwise drop the new frame, keep the held data, and set overrun.
- valid clears on valid && ready unless a frame loads in the same cycle, in which case valid stays 1 with the new data.
- overrun and frame_err clear only on reset.

## Timing
- Reset values: left_data=0, right_data=0, valid=0, overrun=0, frame_err=0, state SYNC, counters 0.
- Latency: valid rises on the 4th clk edge after the bck pin rise carrying the right LSB (2 sync stages, 1 edge detect, 1 output register).
- Reset asserted mid-frame: all outputs return to reset values immediately and asynchronously. After release, a full SYNC alignment is required before the next valid.
- Consecutive ticks are at least 4 clk apart; behaviour is undefined if bck exceeds clk/4.

## Configuration
- I2S_RX_FRAME_ERR_EN defined: frame_err is set when a slot ends with counter < DATA_W. This is checked at both slot ends in LEFT/RIGHT and never in SYNC.
- Undefined: the port remains and is tied 0, and no check logic is built.

## Structure
- Package i2s_pkg holds the state enum (SYNC, LEFT, RIGHT), SYNC_STAGES=2, and the DATA_W default constant, shared with the DAC driver side.
- One sub-module, i2s_in_sync, contains the 2-flop synchronizers for bck/ws/din plus the bck rise-detect pulse.

## Test plan
- Reset: rst_n low with inputs toggling -> all outputs 0. Release -> no valid before the first ws 1->0 tick.
- Start mid-right-slot, 32-bit slots, then one frame L=24'h800000, R=24'h7FFFFF, ready=1 -> exactly one valid pulse with left_data=24'h800000, right_data=24'h7FFFFF; the partial frame is discarded.
- ready=0 across two frames (L=24'h000001, then L=24'h000002) -> left_data stays 24'h000001, overrun=1. Raising ready -> valid drops after one cycle.
- 16-bit slots with L=16'hABCD, R=16'h1234 -> left_data=24'hABCD00, right_data=24'h123400. frame_err=1 with I2S_RX_FRAME_ERR_EN, 0 without.
- ready=1 continuously, 10 frames of 32-bit slots -> 10 valid pulses and overrun stays 0.
- rst_n pulsed during a LEFT slot -> outputs 0 at once. First valid after release arrives only after the next ws 1->0 edge plus one full frame.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the receive and DAC driver sides.
// Frame state encoding, synchronizer depth and default sample width.
package i2s_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int DATA_W_DEF  = 24;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

  // Write one serial bit into a sample register selected by a one-hot mask.
  function automatic logic [31:0] put_bit(
    input logic [31:0] base,
    input logic [31:0] mask,
    input logic        bit_in
  );
    return (base & ~mask) | (bit_in ? mask : 32'd0);
  endfunction

endpackage

// File: rtl/i2s_in_sync.sv
// Brings bck/ws/din into the clk domain and emits a one-cycle tick
// per bck rise, with ws/din samples aligned to that tick.
module i2s_in_sync
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_bck,
  input  logic i_ws,
  input  logic i_din,
  output logic o_tick,
  output logic o_ws,
  output logic o_din
);

  logic [SYNC_STAGES-1:0] r_bck_s;
  logic [SYNC_STAGES-1:0] r_ws_s;
  logic [SYNC_STAGES-1:0] r_din_s;
  logic                   r_bck_d;
  logic                   r_tick;
  logic                   r_ws;
  logic                   r_din;
  logic                   w_rise;

  assign w_rise = r_bck_s[SYNC_STAGES-1] & ~r_bck_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bck_s <= '0;
      r_ws_s  <= '0;
      r_din_s <= '0;
      r_bck_d <= 1'b0;
      r_tick  <= 1'b0;
      r_ws    <= 1'b0;
      r_din   <= 1'b0;
    end else begin
      r_bck_s <= {r_bck_s[SYNC_STAGES-2:0], i_bck};
      r_ws_s  <= {r_ws_s[SYNC_STAGES-2:0], i_ws};
      r_din_s <= {r_din_s[SYNC_STAGES-2:0], i_din};
      r_bck_d <= r_bck_s[SYNC_STAGES-1];
      // ws/din are stable around bck rise, so take them with the pulse
      r_tick  <= w_rise;
      r_ws    <= r_ws_s[SYNC_STAGES-1];
      r_din   <= r_din_s[SYNC_STAGES-1];
    end
  end

  assign o_tick = r_tick;
  assign o_ws   = r_ws;
  assign o_din  = r_din;

endmodule

// File: rtl/i2s_receiver.sv
// I2S target-mode receiver: deserializes stereo frames into left/right.
// Optional slot-length checking via macro I2S_RX_FRAME_ERR_EN.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bck,
  input  logic              ws,
  input  logic              din,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              valid,
  input  logic              ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0] MSB_ONE =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic              w_tick;
  logic              w_ws_now;
  logic              w_din;

  i2s_state_e        r_state;
  i2s_state_e        w_state_nxt;
  logic              r_ws_d;
  logic              r_ws_dd;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_left_sr;
  logic [DATA_W-1:0] r_right_sr;

  logic [DATA_W-1:0] r_left_q;
  logic [DATA_W-1:0] r_right_q;
  logic              r_valid;
  logic              r_overrun;

  logic              w_slot_start;
  logic              w_slot_end;
  logic [CNT_W-1:0]  w_idx;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_left_nxt;
  logic [DATA_W-1:0] w_right_nxt;
  logic [31:0]       w_left_put;
  logic [31:0]       w_right_put;
  logic              w_frame_done;
  logic              w_load;

  i2s_in_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_bck  (bck),
    .i_ws   (ws),
    .i_din  (din),
    .o_tick (w_tick),
    .o_ws   (w_ws_now),
    .o_din  (w_din)
  );

  assign w_slot_start = r_ws_d != r_ws_dd;
  assign w_slot_end   = r_ws_d != w_ws_now;

  assign w_idx = w_slot_start ? '0 : r_cnt;
  assign w_cnt_nxt = (w_idx < CNT_MAX) ?
    w_idx + CNT_W'(1) : CNT_MAX;

  // Saturated index shifts the mask out, so surplus bits are dropped
  assign w_mask = MSB_ONE >> w_idx;

  assign w_left_put = put_bit(
    32'(w_slot_start ? '0 : r_left_sr),
    32'(w_mask),
    w_din
  );
  assign w_right_put = put_bit(
    32'(w_slot_start ? '0 : r_right_sr),
    32'(w_mask),
    w_din
  );
  assign w_left_nxt  = w_left_put[DATA_W-1:0];
  assign w_right_nxt = w_right_put[DATA_W-1:0];

  assign w_frame_done = w_tick && (r_state == RIGHT) &&
                        w_slot_end && !w_ws_now;

  assign w_load = w_frame_done && (!r_valid || ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SYNC: begin
        if (w_tick && w_slot_end && !w_ws_now) begin
          w_state_nxt = LEFT;
        end
      end
      LEFT: begin
        if (w_tick && w_slot_end && w_ws_now) begin
          w_state_nxt = RIGHT;
        end
      end
      RIGHT: begin
        if (w_frame_done) begin
          w_state_nxt = LEFT;
        end
      end
      default: w_state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws_d     <= 1'b0;
      r_ws_dd    <= 1'b0;
      r_cnt      <= '0;
      r_left_sr  <= '0;
      r_right_sr <= '0;
    end else if (w_tick) begin
      r_ws_d  <= w_ws_now;
      r_ws_dd <= r_ws_d;
      r_cnt   <= w_cnt_nxt;
      if (r_state == LEFT) begin
        r_left_sr <= w_left_nxt;
      end
      if (r_state == RIGHT) begin
        r_right_sr <= w_right_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left_q  <= '0;
      r_right_q <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      r_left_q  <= r_left_sr;
      r_right_q <= w_right_nxt;
      r_valid   <= 1'b1;
    end else if (w_frame_done) begin
      r_overrun <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  logic r_frame_err;
  logic w_err_set;

  assign w_err_set = w_tick && w_slot_end &&
                     (r_state == LEFT || r_state == RIGHT) &&
                     (w_cnt_nxt < CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else if (w_err_set) begin
      r_frame_err <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

  assign left_data  = r_left_q;
  assign right_data = r_right_q;
  assign valid      = r_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver with a slot-level reference model.
module tb_i2s_receiver;

  localparam int DW = 24;
  localparam int HB = 37;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bck = 1'b0;
  logic          ws = 1'b0;
  logic          din = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          valid;
  logic          overrun;
  logic          frame_err;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } fr_t;

  fr_t q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  n_hs = 0;

  i2s_receiver #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bck        (bck),
    .ws         (ws),
    .din        (din),
    .left_data  (left_data),
    .right_data (right_data),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Captured sample = top min(s,DW) slot bits, MSB-aligned, zero-filled.
  function automatic logic [DW-1:0] model(input logic [31:0] v,
                                          input int s);
    logic [63:0] t;
    t = 64'(v) & ((64'd1 << s) - 64'd1);
    if (s >= DW) t = t >> (s - DW);
    else t = t << (DW - s);
    return t[DW-1:0];
  endfunction

  task automatic send_bit(input logic w, input logic d);
    bck = 1'b0;
    ws  = w;
    din = d;
    #HB;
    bck = 1'b1;
    #HB;
  endtask

  // ws flips one bit early: the slot's last bit already carries the next ws.
  task automatic send_slot(input logic w, input int s,
                           input logic [31:0] v);
    for (int i = s - 1; i >= 0; i--) begin
      send_bit((i == 0) ? ~w : w, v[i]);
    end
  endtask

  task automatic send_frame(input logic [31:0] lv,
                            input logic [31:0] rv, input int s);
    send_slot(1'b0, s, lv);
    send_slot(1'b1, s, rv);
  endtask

  task automatic push_send(input logic [31:0] lv,
                           input logic [31:0] rv, input int s);
    fr_t e;
    e.l = model(lv, s);
    e.r = model(rv, s);
    q.push_back(e);
    send_frame(lv, rv, s);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_left"}, 64'(left_data), 64'd0);
    chk({tag, "_right"}, 64'(right_data), 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
  endtask

  always @(negedge clk) begin
    fr_t e;
    if (rst_n && valid && ready) begin
      n_hs++;
      chk("unexpected_valid", 64'(q.size() == 0), 64'd0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("left_data", 64'(left_data), 64'(e.l));
        chk("right_data", 64'(right_data), 64'(e.r));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    logic exp_err;

    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'($urandom), 1'($urandom));
    end
    chk_zero("in_reset");
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) send_bit(1'b0, 1'($urandom));
    for (int i = 0; i < 30; i++) send_bit(1'b1, 1'($urandom));
    repeat (10) @(negedge clk);
    chk("no_valid_unsynced", 64'(valid), 64'd0);
    chk("no_hs_unsynced", 64'(n_hs), 64'd0);

    ready = 1'b1;
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'($urandom));
    send_bit(1'b0, 1'($urandom));
    push_send({24'h800000, 8'($urandom)},
              {24'h7FFFFF, 8'($urandom)}, 32);
    wait_drain();
    chk("first_frame_hs", 64'(n_hs), 64'd1);
    chk("first_left", 64'(left_data), 64'h800000);
    chk("first_right", 64'(right_data), 64'h7FFFFF);

    hs0 = n_hs;
    for (int k = 0; k < 10; k++) begin
      push_send($urandom, $urandom, 32);
    end
    wait_drain();
    chk("ten_frames_hs", 64'(n_hs - hs0), 64'd10);
    chk("ten_overrun", 64'(overrun), 64'd0);
    chk("ten_frame_err", 64'(frame_err), 64'd0);

    for (int k = 0; k < 3; k++) begin
      push_send($urandom, $urandom, 24);
    end
    wait_drain();
    chk("exact_slot_err", 64'(frame_err), 64'd0);

    push_send(32'h0000ABCD, 32'h00001234, 16);
    wait_drain();
    chk("short_left", 64'(left_data), 64'hABCD00);
    chk("short_right", 64'(right_data), 64'h123400);
`ifdef I2S_RX_FRAME_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    chk("short_frame_err", 64'(frame_err), 64'(exp_err));

    @(posedge clk);
    #1 ready = 1'b0;
    q.push_back('{l: 24'h000001, r: model(32'h00ABC100, 32)});
    send_frame({24'h000001, 8'($urandom)}, 32'h00ABC100, 32);
    send_frame({24'h000002, 8'($urandom)}, $urandom, 32);
    repeat (20) @(negedge clk);
    chk("hold_valid", 64'(valid), 64'd1);
    chk("hold_left", 64'(left_data), 64'h000001);
    chk("overrun_set", 64'(overrun), 64'd1);
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drop", 64'(valid), 64'd0);
    chk("hold_popped", 64'(q.size()), 64'd0);

    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom));
    #3 rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    #20 rst_n = 1'b1;
    hs0 = n_hs;
    send_slot(1'b0, 22, $urandom);
    send_slot(1'b1, 32, $urandom);
    repeat (20) @(negedge clk);
    chk("realign_no_hs", 64'(n_hs - hs0), 64'd0);
    push_send($urandom, $urandom, 32);
    wait_drain();
    chk("realign_hs", 64'(n_hs - hs0), 64'd1);
    chk("final_overrun", 64'(overrun), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
